// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel 3x3 window generator: default image
// geometry, pixel and coordinate widths, and the frame-sequencing states.
package sobel_pkg;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
    localparam int PIX_W          = 8;
    localparam int COORD_W        = 16;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage: single clock, one write port and one
// registered read port, written so that synthesis maps it onto block RAM.
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    // NOTE: storage and read register carry no reset; a reset would stop the
    // array from mapping onto block RAM, and every entry is rewritten before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Turns a raster pixel stream into 3x3 neighbourhoods for a Sobel filter,
// tagging each window with its centre coordinate and marking end of frame.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic [9*PIX_W-1:0] win_out,
    output logic               win_valid,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic               frame_done
);

    localparam int AW = $clog2(IMG_WIDTH);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

    logic [COORD_W-1:0]        x, y, x_next, y_next;
    state_t                    state, state_next;
    logic                      win_valid_next, frame_done_next;
    logic [PIX_W-1:0]          line0_q, line1_q;
    logic [8:0][PIX_W-1:0]     win;
    logic                      last_col, last_px;

    assign last_col = (x == X_LAST);
    assign last_px  = last_col && (y == Y_LAST);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        x_next = x;
        y_next = y;
        if (pix_valid) begin
            if (last_col) begin
                x_next = '0;
                y_next = (y == Y_LAST) ? '0 : y + 16'd1;
            end else begin
                x_next = x + 16'd1;
            end
        end
    end

    always_comb begin
        state_next      = state;
        win_valid_next  = 1'b0;
        frame_done_next = 1'b0;
        case (state)
            ST_FILL: begin
                if (pix_valid && last_col && (y == 16'd1)) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                win_valid_next = pix_valid && (x >= 16'd2);
                if (pix_valid && last_px) begin
                    state_next      = ST_FLUSH;
                    frame_done_next = 1'b1;
                end
            end
            // Any pixel accepted here is (0,0) of the next frame, which never
            // completes a window, so FILL can take over directly.
            ST_FLUSH: state_next = ST_FILL;
            default:  state_next = ST_FILL;
        endcase
    end

    // Reads are addressed by the column about to be accepted, so the registered
    // read data is already current when that pixel arrives.
    line_buffer #(.DEPTH(IMG_WIDTH)) u_line0 (
        .clk     (clk),
        .rd_addr (x_next[AW-1:0]),
        .rd_data (line0_q),
        .wr_en   (pix_valid),
        .wr_addr (x[AW-1:0]),
        .wr_data (line1_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_line1 (
        .clk     (clk),
        .rd_addr (x_next[AW-1:0]),
        .rd_data (line1_q),
        .wr_en   (pix_valid),
        .wr_addr (x[AW-1:0]),
        .wr_data (pix_in)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_FILL;
            x          <= '0;
            y          <= '0;
            win        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            cx         <= '0;
            cy         <= '0;
        end else begin
            state      <= state_next;
            x          <= x_next;
            y          <= y_next;
            win_valid  <= win_valid_next;
            frame_done <= frame_done_next;
            if (pix_valid) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= line0_q;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= line1_q;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= pix_in;
            end
            if (win_valid_next) begin
                cx <= x - 16'd1;
                cy <= y - 16'd1;
            end
        end
    end

    assign win_out = win;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: three instances (4x3, 3x3, 640x48)
// checked against windows cut directly from a stored copy of each frame.
module tb_sobel_window_gen;

    localparam int W0 = 4,   H0 = 3;
    localparam int W1 = 3,   H1 = 3;
    localparam int W2 = 640, H2 = 48;

    typedef struct {
        int          cyc;
        logic [15:0] cx;
        logic [15:0] cy;
        logic [71:0] win;
        logic        fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn [3];
    logic [7:0]  pix  [3];
    logic        vld  [3];
    logic [71:0] wout [3];
    logic        wv   [3];
    logic [15:0] ocx  [3];
    logic [15:0] ocy  [3];
    logic        fd   [3];

    logic [7:0]  img [3][0:W2*H2-1];
    int          mx [3];
    int          my [3];
    int          win_cnt [3];
    int          fd_cnt  [3];
    exp_t        sb [3][$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sobel_window_gen #(.IMG_WIDTH(W0), .IMG_HEIGHT(H0)) dut_a (
        .clk(clk), .rstn(rstn[0]), .pix_in(pix[0]), .pix_valid(vld[0]),
        .win_out(wout[0]), .win_valid(wv[0]), .cx(ocx[0]), .cy(ocy[0]),
        .frame_done(fd[0])
    );

    sobel_window_gen #(.IMG_WIDTH(W1), .IMG_HEIGHT(H1)) dut_b (
        .clk(clk), .rstn(rstn[1]), .pix_in(pix[1]), .pix_valid(vld[1]),
        .win_out(wout[1]), .win_valid(wv[1]), .cx(ocx[1]), .cy(ocy[1]),
        .frame_done(fd[1])
    );

    sobel_window_gen #(.IMG_WIDTH(W2), .IMG_HEIGHT(H2)) dut_c (
        .clk(clk), .rstn(rstn[2]), .pix_in(pix[2]), .pix_valid(vld[2]),
        .win_out(wout[2]), .win_valid(wv[2]), .cx(ocx[2]), .cy(ocy[2]),
        .frame_done(fd[2])
    );

    function automatic int img_w(input int d);
        case (d)
            0:       return W0;
            1:       return W1;
            default: return W2;
        endcase
    endfunction

    function automatic int img_h(input int d);
        case (d)
            0:       return H0;
            1:       return H1;
            default: return H2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] ref_window(input int d, input int x, input int y);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[8*(r*3+c) +: 8] = img[d][(y-2+r)*img_w(d) + (x-2+c)];
            end
        end
        return w;
    endfunction

    // Called at posedge+1: pixel is accepted on the next rising edge.
    task automatic send(input int d, input logic [7:0] p);
        exp_t e;
        img[d][my[d]*img_w(d) + mx[d]] = p;
        pix[d] = p;
        vld[d] = 1'b1;
        if (mx[d] >= 2 && my[d] >= 2) begin
            e.cyc = cyc + 1;
            e.cx  = 16'(mx[d] - 1);
            e.cy  = 16'(my[d] - 1);
            e.win = ref_window(d, mx[d], my[d]);
            e.fd  = (mx[d] == img_w(d) - 1) && (my[d] == img_h(d) - 1);
            sb[d].push_back(e);
        end
        if (mx[d] == img_w(d) - 1) begin
            mx[d] = 0;
            my[d] = (my[d] == img_h(d) - 1) ? 0 : my[d] + 1;
        end else begin
            mx[d] = mx[d] + 1;
        end
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        check($sformatf("%s_win_out[%0d]", tag, d), wout[d], 72'd0);
        check($sformatf("%s_win_valid[%0d]", tag, d), {71'd0, wv[d]}, 72'd0);
        check($sformatf("%s_frame_done[%0d]", tag, d), {71'd0, fd[d]}, 72'd0);
        check($sformatf("%s_cx[%0d]", tag, d), {56'd0, ocx[d]}, 72'd0);
        check($sformatf("%s_cy[%0d]", tag, d), {56'd0, ocy[d]}, 72'd0);
    endtask

    task automatic monitor_dut(input int d);
        exp_t e;
        if (wv[d]) win_cnt[d]++;
        if (fd[d]) fd_cnt[d]++;
        if (sb[d].size() > 0 && sb[d][0].cyc == cyc) begin
            e = sb[d].pop_front();
            check($sformatf("win_valid[%0d] (%0d,%0d)", d, e.cx, e.cy), {71'd0, wv[d]}, 72'd1);
            check($sformatf("cx[%0d] (%0d,%0d)", d, e.cx, e.cy), {56'd0, ocx[d]}, {56'd0, e.cx});
            check($sformatf("cy[%0d] (%0d,%0d)", d, e.cx, e.cy), {56'd0, ocy[d]}, {56'd0, e.cy});
            check($sformatf("win_out[%0d] (%0d,%0d)", d, e.cx, e.cy), wout[d], e.win);
            check($sformatf("frame_done[%0d] (%0d,%0d)", d, e.cx, e.cy), {71'd0, fd[d]}, {71'd0, e.fd});
        end else if (wv[d] || fd[d]) begin
            check($sformatf("unexpected_output[%0d] cyc %0d", d, cyc), {70'd0, wv[d], fd[d]}, 72'd0);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) monitor_dut(d);
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rstn[d]    = 1'b0;
            vld[d]     = 1'b0;
            pix[d]     = 8'd0;
            mx[d]      = 0;
            my[d]      = 0;
            win_cnt[d] = 0;
            fd_cnt[d]  = 0;
        end
        idle(3);
        for (int d = 0; d < 3; d++) check_zero(d, "reset");
        for (int d = 0; d < 3; d++) rstn[d] = 1'b1;
        idle(1);

        // Back-to-back frame 0..11, then a second frame 100..111 with no gap.
        for (int i = 0; i < 12; i++) send(0, 8'(i));
        for (int i = 0; i < 12; i++) send(0, 8'(100 + i));
        idle(3);

        // Same frame with pix_valid toggling 1-0-1-0.
        for (int i = 0; i < 12; i++) begin
            send(0, 8'(i));
            idle(1);
        end
        idle(3);

        // Reset after 7 pixels, then a complete fresh frame.
        for (int i = 0; i < 7; i++) send(0, 8'(50 + i));
        rstn[0] = 1'b0;
        #1;
        check_zero(0, "midframe_reset");
        @(posedge clk);
        #1;
        rstn[0] = 1'b1;
        mx[0] = 0;
        my[0] = 0;
        idle(1);
        for (int i = 0; i < 12; i++) send(0, 8'(i));
        idle(3);

        // Minimum 3x3 image.
        for (int i = 0; i < 9; i++) send(1, 8'(i));
        idle(3);

        // Full-width random frame with occasional gaps.
        for (int i = 0; i < W2*H2; i++) begin
            send(2, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 15) == 0) idle(1);
        end
        idle(4);

        for (int d = 0; d < 3; d++) begin
            check($sformatf("scoreboard_drained[%0d]", d), 72'(sb[d].size()), 72'd0);
        end
        check("window_count[0]", 72'(win_cnt[0]), 72'd8);
        check("frame_done_count[0]", 72'(fd_cnt[0]), 72'd4);
        check("window_count[1]", 72'(win_cnt[1]), 72'd1);
        check("frame_done_count[1]", 72'(fd_cnt[1]), 72'd1);
        check("window_count[2]", 72'(win_cnt[2]), 72'((W2-2)*(H2-2)));
        check("frame_done_count[2]", 72'(fd_cnt[2]), 72'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
